fetch_prefetch: RTL and testbench

- Parametrised successor to the single-word fetch unit. Issues aligned word reads to instruction memory, with up to MAX_OUTSTANDING requests in flight.
- Buffers returned bytes in a byte queue and extracts variable-length instructions of 1/2/4/8 bytes, little-endian, for decode.
- Supports PC redirect: flushes the queue and discards responses still in flight.
- Sits between the memory module (request/response side) and decode (instruction side).

---
 rtl/fetch_prefetch.sv | 171 +++++++++++++++++
 tb/tb_fetch_prefetch.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch.sv
// Instruction prefetcher: issues aligned word reads and extracts 1/2/4/8-byte instructions
// from a byte queue. Define FETCH_PERF_CNT_EN to add the handoff/stall performance counters.
module fetch_prefetch #(
   parameter int                         ADDRESS_WIDTH   = 32,
   parameter int                         DATA_WIDTH      = 32,
   parameter int                         MAX_INSTR_BYTES = 8,
   parameter int                         BUF_BYTES       = 16,
   parameter int                         MAX_OUTSTANDING = 2,
   parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC        = '0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          i_pc_valid,
   input  logic [ADDRESS_WIDTH-1:0]      i_pc,
   output logic                          o_ready,
   output logic                          o_addr_valid,
   output logic [ADDRESS_WIDTH-1:0]      o_addr,
   input  logic                          i_mem_ready,
   input  logic                          i_mem_valid,
   input  logic [DATA_WIDTH-1:0]         i_mem_data,
   output logic                          o_res_valid,
   output logic [8*MAX_INSTR_BYTES-1:0]  o_instr,
   output logic [3:0]                    o_instr_len,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]                   o_perf_instr_cnt,
   output logic [31:0]                   o_perf_stall_cnt,
`endif
   input  logic                          i_dec_ready
);

   localparam int WB = DATA_WIDTH / 8;
   localparam int CW = $clog2(BUF_BYTES + 1);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int IW = $clog2(BUF_BYTES);
   localparam int SW = (WB > 1) ? $clog2(WB) : 1;
   localparam logic [ADDRESS_WIDTH-1:0] WB_A = ADDRESS_WIDTH'(WB);

   // state | meaning
   // RUN   | normal fetch, redirects accepted
   // FLUSH | dropping responses of the pre-redirect stream
   typedef enum logic {ST_RUN, ST_FLUSH} state_t;

   state_t                   r_state;
   logic [ADDRESS_WIDTH-1:0] r_pc;
   logic [SW-1:0]            r_skip;
   logic [CW-1:0]            r_count;
   logic [OW-1:0]            r_outst;
   logic [OW-1:0]            r_discard;
   logic [7:0]               r_buf [BUF_BYTES];

   logic [3:0]               w_len;
   logic                     w_nonempty;
   logic                     w_res_valid;
   logic                     w_addr_valid;
   logic                     w_accept;
   logic                     w_handoff;
   logic                     w_redirect;
   logic [OW-1:0]            w_outst_n;
   logic [CW-1:0]            w_count_n;
   logic [7:0]               w_buf_n [BUF_BYTES];
   int                       w_pop;
   int                       w_cnt;
   int                       w_idx;

   always_comb begin
      case (r_buf[0][1:0])
         2'b00:   w_len = 4'd1;
         2'b01:   w_len = 4'd2;
         2'b10:   w_len = 4'd4;
         default: w_len = 4'd8;
      endcase
   end

   assign w_nonempty   = !reset && (r_count != '0);
   assign w_res_valid  = w_nonempty && (int'(r_count) >= int'(w_len));
   // Reserve room for every in-flight word so a response can never overflow the queue.
   assign w_addr_valid = !reset && (int'(r_outst) < MAX_OUTSTANDING) &&
                         (int'(r_count) + (int'(r_outst) + 1) * WB <= BUF_BYTES);
   assign w_accept     = w_addr_valid && i_mem_ready;
   assign w_handoff    = w_res_valid && i_dec_ready;
   assign w_redirect   = !reset && i_pc_valid && (r_state == ST_RUN);
   assign w_outst_n    = OW'(int'(r_outst) + int'(w_accept) - int'(i_mem_valid));

   always_comb begin
      w_pop = w_handoff ? int'(w_len) : 0;
      w_cnt = int'(r_count) - w_pop;
      w_idx = 0;
      for (int i = 0; i < BUF_BYTES; i++)
         w_buf_n[i] = (i + w_pop < BUF_BYTES) ? r_buf[IW'(i + w_pop)] : 8'h00;
      if (i_mem_valid && (r_discard == '0)) begin
         for (int j = 0; j < WB; j++) begin
            w_idx = w_cnt + j - int'(r_skip);
            if (j >= int'(r_skip) && w_idx >= 0 && w_idx < BUF_BYTES)
               w_buf_n[IW'(w_idx)] = i_mem_data[8*j +: 8];
         end
         w_cnt = w_cnt + WB - int'(r_skip);
      end
      w_count_n = CW'(w_cnt);
   end

   always_comb begin
      o_instr = '0;
      for (int k = 0; k < MAX_INSTR_BYTES; k++)
         if (w_nonempty && k < int'(w_len) && k < BUF_BYTES)
            o_instr[8*k +: 8] = r_buf[k];
   end

   assign o_instr_len  = w_nonempty ? w_len : 4'd0;
   assign o_res_valid  = w_res_valid;
   assign o_addr_valid = w_addr_valid;
   assign o_addr       = r_pc;
   assign o_ready      = reset || (r_state == ST_RUN);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_RUN;
         r_pc      <= RESET_PC - (RESET_PC % WB_A);
         r_skip    <= SW'(RESET_PC % WB_A);
         r_count   <= '0;
         r_outst   <= '0;
         r_discard <= '0;
         for (int i = 0; i < BUF_BYTES; i++)
            r_buf[i] <= 8'h00;
      end else begin
         r_outst <= w_outst_n;
         if (w_accept)
            r_pc <= r_pc + WB_A;
         if (w_redirect) begin
            // A response arriving now is already excluded from w_outst_n, so it is not counted.
            r_count   <= '0;
            r_pc      <= i_pc - (i_pc % WB_A);
            r_skip    <= SW'(i_pc % WB_A);
            r_discard <= w_outst_n;
            r_state   <= (w_outst_n != '0) ? ST_FLUSH : ST_RUN;
         end else begin
            r_buf   <= w_buf_n;
            r_count <= w_count_n;
            if (i_mem_valid) begin
               if (r_discard != '0) begin
                  r_discard <= r_discard - OW'(1);
                  if (r_discard == OW'(1))
                     r_state <= ST_RUN;
               end else begin
                  r_skip <= '0;
               end
            end
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_perf_instr;
   logic [31:0] r_perf_stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_perf_instr <= '0;
         r_perf_stall <= '0;
      end else begin
         if (w_handoff)
            r_perf_instr <= r_perf_instr + 32'd1;
         if (!w_res_valid)
            r_perf_stall <= r_perf_stall + 32'd1;
      end
   end

   assign o_perf_instr_cnt = r_perf_instr;
   assign o_perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: byte-queue reference model, in-order memory model, and
// a stream checker that re-parses memory at the current PC for each delivered instruction.
module tb_fetch_prefetch;

   localparam int WB   = 4;
   localparam int BUFB = 16;
   localparam int MAXO = 2;
   localparam int MM   = 1023;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_pc_valid;
   logic [31:0] i_pc;
   logic        o_ready;
   logic        o_addr_valid;
   logic [31:0] o_addr;
   logic        i_mem_ready;
   logic        i_mem_valid;
   logic [31:0] i_mem_data;
   logic        o_res_valid;
   logic [63:0] o_instr;
   logic [3:0]  o_instr_len;
   logic        i_dec_ready;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] o_perf_instr_cnt;
   logic [31:0] o_perf_stall_cnt;
`endif

   fetch_prefetch dut (
      .clk              (clk),
      .reset            (reset),
      .i_pc_valid       (i_pc_valid),
      .i_pc             (i_pc),
      .o_ready          (o_ready),
      .o_addr_valid     (o_addr_valid),
      .o_addr           (o_addr),
      .i_mem_ready      (i_mem_ready),
      .i_mem_valid      (i_mem_valid),
      .i_mem_data       (i_mem_data),
      .o_res_valid      (o_res_valid),
      .o_instr          (o_instr),
      .o_instr_len      (o_instr_len),
`ifdef FETCH_PERF_CNT_EN
      .o_perf_instr_cnt (o_perf_instr_cnt),
      .o_perf_stall_cnt (o_perf_stall_cnt),
`endif
      .i_dec_ready      (i_dec_ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc;

   logic [7:0]  mem [1024];
   logic [7:0]  mq [$];
   int          pend_due [$];
   logic [31:0] pend_addr [$];
   logic [31:0] acc_addr [$];
   logic [63:0] deliv [$];
   int          deliv_len [$];
   int          m_out, m_disc, m_skip, last_due, lat_min, lat_max;
   logic [31:0] m_pc, s_addr;
   int          m_pinstr, m_pstall;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      for (int k = 0; k < WB; k++) w[8*k +: 8] = mem[(a + k) & MM];
      return w;
   endfunction

   function automatic logic [63:0] mem_instr(input logic [31:0] a);
      logic [63:0] v;
      logic [7:0]  h;
      int          n;
      v = '0;
      h = mem[a & MM];
      n = 1 << h[1:0];
      for (int k = 0; k < n; k++) v[8*k +: 8] = mem[(a + k) & MM];
      return v;
   endfunction

   task automatic fill(input bit rnd, input logic [7:0] v);
      for (int i = 0; i < 1024; i++) mem[i] = rnd ? 8'($urandom) : v;
   endtask

   task automatic do_reset();
      reset = 1'b1; i_pc_valid = 1'b0; i_pc = '0; i_mem_ready = 1'b0;
      i_mem_valid = 1'b0; i_mem_data = '0; i_dec_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ready", o_ready, 1);
      chk("rst_addr_valid", o_addr_valid, 0);
      chk("rst_addr", o_addr, 0);
      chk("rst_res_valid", o_res_valid, 0);
      chk("rst_instr", o_instr, 0);
      chk("rst_len", o_instr_len, 0);
`ifdef FETCH_PERF_CNT_EN
      chk("rst_perf_instr", o_perf_instr_cnt, 0);
      chk("rst_perf_stall", o_perf_stall_cnt, 0);
`endif
      mq.delete(); pend_due.delete(); pend_addr.delete();
      acc_addr.delete(); deliv.delete(); deliv_len.delete();
      m_out = 0; m_disc = 0; m_skip = 0; m_pc = '0; s_addr = '0;
      last_due = -1; cyc = 0; m_pinstr = 0; m_pstall = 0;
      reset = 1'b0;
   endtask

   // One clock cycle: drive inputs, compare against the model, advance the model.
   task automatic cycle(input bit mr, input bit dr, input bit pv, input logic [31:0] pc);
      bit          rv, e_rv, e_av, e_rdy, acc, ho, rd;
      logic [31:0] rdat;
      logic [7:0]  h;
      logic [63:0] e_instr;
      int          e_len, due;
      rv = 1'b0; rdat = '0;
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
         rv = 1'b1;
         rdat = mem_word(pend_addr[0]);
         void'(pend_due.pop_front());
         void'(pend_addr.pop_front());
      end
      i_mem_valid = rv; i_mem_data = rdat; i_mem_ready = mr;
      i_dec_ready = dr; i_pc_valid = pv; i_pc = pc;
      #1;
      h     = (mq.size() > 0) ? mq[0] : 8'h00;
      e_len = 1 << h[1:0];
      e_rv  = (mq.size() > 0) && (mq.size() >= e_len);
      e_av  = (m_out < MAXO) && (mq.size() + (m_out + 1) * WB <= BUFB);
      e_rdy = (m_disc == 0);
      e_instr = '0;
      if (e_rv) for (int k = 0; k < e_len; k++) e_instr[8*k +: 8] = mq[k];
      chk("ready", o_ready, e_rdy);
      chk("addr_valid", o_addr_valid, e_av);
      chk("res_valid", o_res_valid, e_rv);
      if (e_av) chk("addr", o_addr, m_pc);
      if (e_rv) begin
         chk("instr", o_instr, e_instr);
         chk("len", o_instr_len, e_len);
      end
`ifdef FETCH_PERF_CNT_EN
      chk("perf_instr", o_perf_instr_cnt, m_pinstr);
      chk("perf_stall", o_perf_stall_cnt, m_pstall);
`endif
      acc = e_av && mr;
      ho  = e_rv && dr;
      rd  = pv && e_rdy;
      if (ho) begin
         chk("stream", o_instr, mem_instr(s_addr));
         deliv.push_back(o_instr);
         deliv_len.push_back(int'(o_instr_len));
         s_addr = s_addr + e_len;
         for (int k = 0; k < e_len; k++) void'(mq.pop_front());
         m_pinstr++;
      end
      if (!e_rv) m_pstall++;
      m_out = m_out + int'(acc) - int'(rv);
      if (acc) begin
         due = cyc + int'($urandom_range(lat_min, lat_max));
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         pend_due.push_back(due);
         pend_addr.push_back(m_pc);
         acc_addr.push_back(m_pc);
         m_pc = m_pc + WB;
      end
      if (rd) begin
         mq.delete();
         m_pc   = pc & 32'hFFFF_FFFC;
         m_skip = int'(pc[1:0]);
         m_disc = m_out;
         s_addr = pc;
      end else if (rv) begin
         if (m_disc > 0) m_disc--;
         else begin
            for (int j = m_skip; j < WB; j++) mq.push_back(rdat[8*j +: 8]);
            m_skip = 0;
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic run(input int n, input int mr_pct, input int dr_pct, input int rd_pct);
      for (int i = 0; i < n; i++)
         cycle($urandom_range(0, 99) < mr_pct, $urandom_range(0, 99) < dr_pct,
               $urandom_range(0, 99) < rd_pct, 32'($urandom_range(0, MM)));
   endtask

   int n_f;
   int f_tries;

   initial begin
      // Streaming len-2 instructions from 0x01 bytes
      lat_min = 1; lat_max = 1;
      fill(1'b0, 8'h01);
      do_reset();
      run(30, 100, 100, 0);
      chk("b_addr0", acc_addr[0], 32'h0);
      chk("b_addr1", acc_addr[1], 32'h4);
      chk("b_addr2", acc_addr[2], 32'h8);
      chk("b_instr0", deliv[0], 64'h0101);
      chk("b_len0", deliv_len[0], 2);
      chk("b_count", deliv.size(), 28);

      // Mixed lengths 1,2,4,8
      fill(1'b0, 8'h00);
      mem[0] = 8'h00; mem[1] = 8'h01; mem[2] = 8'hAA; mem[3] = 8'h02;
      mem[4] = 8'hBB; mem[5] = 8'hCC; mem[6] = 8'hDD; mem[7] = 8'h03;
      for (int i = 0; i < 7; i++) mem[8 + i] = 8'h11 + 8'(i);
      do_reset();
      run(20, 100, 100, 0);
      chk("c_i0", deliv[0], 64'h00);
      chk("c_l0", deliv_len[0], 1);
      chk("c_i1", deliv[1], 64'hAA01);
      chk("c_l1", deliv_len[1], 2);
      chk("c_i2", deliv[2], 64'hDDCCBB02);
      chk("c_l2", deliv_len[2], 4);
      chk("c_i3", deliv[3], 64'h1716151413121103);
      chk("c_l3", deliv_len[3], 8);

      // Decode stalled: queue plus in-flight capped at 16 bytes
      fill(1'b1, 8'h00);
      do_reset();
      run(20, 100, 0, 0);
      #1;
      chk("d_accepts", acc_addr.size(), 4);
      chk("d_held_instr", o_instr, mem_instr(32'h0));
      run(30, 100, 100, 0);

      // Redirect to 0x103 with two requests in flight, 3-cycle memory
      lat_min = 3; lat_max = 3;
      fill(1'b1, 8'h00);
      mem[32'h103] = 8'h5C;
      do_reset();
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      cycle(1'b1, 1'b0, 1'b1, 32'h103);
      #1;
      chk("e_flush_ready_a", o_ready, 0);
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      #1;
      chk("e_flush_ready_b", o_ready, 0);
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      #1;
      chk("e_run_ready", o_ready, 1);
      run(12, 100, 100, 0);
      chk("e_new_addr", acc_addr[2], 32'h100);
      chk("e_first_instr", deliv[0], 64'h5C);
      chk("e_first_len", deliv_len[0], 1);

      // Redirect coinciding with a handoff and a memory response
      lat_min = 1; lat_max = 1;
      fill(1'b0, 8'h00);
      mem[32'h200] = 8'h34;
      do_reset();
      run(4, 100, 100, 0);
      f_tries = 0;
      while (!(pend_due.size() > 0 && pend_due[0] == cyc) && f_tries < 20) begin
         cycle(1'b1, 1'b1, 1'b0, 32'h0);
         f_tries++;
      end
      chk("f_resp_found", f_tries < 20, 1);
      chk("f_res_valid", o_res_valid, 1);
      n_f = deliv.size();
      cycle(1'b1, 1'b1, 1'b1, 32'h200);
      run(8, 100, 100, 0);
      chk("f_redir_instr", deliv[n_f], 64'h00);
      chk("f_next_instr", deliv[n_f + 1], 64'h34);
      chk("f_next_len", deliv_len[n_f + 1], 1);

      // Randomized traffic, latencies and redirects
      for (int s = 0; s < 6; s++) begin
         lat_min = 1;
         lat_max = int'($urandom_range(1, 4));
         fill(1'b1, 8'h00);
         do_reset();
         run(400, int'($urandom_range(40, 100)), int'($urandom_range(30, 100)), 4);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
